cordic_dualmode: RTL
====================

# cordic_dualmode

Iterative, parametrised CORDIC engine that runs either vectoring mode (magnitude/phase of an (x,y) pair) or rotation mode (rotate (x,y) by an angle z), selected per transaction. It has full-quadrant pre-rotation, optional CORDIC-gain compensation and a valid/ready handshake with output backpressure. It is the next generation of the magnitude/phase unit and sits between the sample front-end and the downstream phase/amplitude consumers.

## Interface
- INPUT_WIDTH, 16: signed width of x_in/y_in; sign-extended to INT_WIDTH internally.
- INT_WIDTH, 32: datapath and output width; must be ≥ 32 and ≥ INPUT_WIDTH+3.
- ITERATIONS, 16: micro-rotations, legal range 1..24.
- COMPENSATE, 1: 1 scales x/y by 1/K; 0 leaves CORDIC gain (≈1.64676) in the result.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- mode_in  input  1  0 = vectoring, 1 = rotation; captured with the request.
- x_in, y_in  input  INPUT_WIDTH  signed operands.
- z_in  input  INT_WIDTH  signed angle in Q3.28 radians (2^28 = 1 rad); ignored in vectoring.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- x_out, y_out, z_out  output  INT_WIDTH  signed results.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- Constants: π/2 = 421657428 and π = 843314857 (Q3.28). The atan table holds round(atan(2^-i)·2^28) for i = 0..23.
- Acceptance occurs when in_valid & in_ready are both high at a clock edge. mode_in, the sign-extended x/y and z_in (vectoring: 0) are captured.
- States are IDLE → PRE → ITER → COMP → DONE → IDLE.
- PRE, vectoring:
  - x<0, y≥0: (x,y) ← (y,−x), z ← +π/2.
  - x<0, y<0: (x,y) ← (−y,x), z ← −π/2.
  - Otherwise unchanged.
- PRE, rotation:
  - z>π/2: (x,y) ← (−y,x), z −= π/2.
  - z<−π/2: (x,y) ← (y,−x), z += π/2.
  - Otherwise unchanged.
  - z_in outside ±π is undefined.
- ITER runs iteration i = 0..ITERATIONS−1, one per cycle, with arithmetic shifts (>>>).
  - Vectoring, y≥0: x += y>>>i, y −= x>>>i, z += atan_i. Opposite signs when y<0.
  - Rotation, z≥0: x −= y>>>i, y += x>>>i, z −= atan_i. Opposite signs when z<0.
  - Updates of x and y use the pre-iteration values.
- COMP, when COMPENSATE=1: x ← (x·39797)>>>16 and y ← (y·39797)>>>16, using a full-width signed product. When COMPENSATE=0 this state is a pass-through. z is unchanged.
- Zero vector: vectoring with x_in = y_in = 0 forces z_out = 0 in COMP. x_out and y_out are naturally 0.
- Results:
  - Vectoring: x_out = magnitude, z_out = phase in (−π, π], y_out = residual (≈0).
  - Rotation: x_out/y_out = rotated vector, z_out = residual angle (≈0).
- DONE: out_valid = 1 and outputs are stable. On out_ready the block returns to IDLE.

## Timing
- Reset (async, any state): state IDLE; x_out, y_out, z_out = 0; out_valid = 0; busy = 0; in_ready = 1 (combinational from IDLE).
- Latency: out_valid rises ITERATIONS+2 edges after the acceptance edge (18 for the default).
- Throughput: one transaction per ITERATIONS+4 cycles at minimum. in_ready stays 0 from the acceptance edge until the block is back in IDLE, so no back-to-back acceptance in the DONE cycle.
- out_ready low in DONE holds every output unchanged indefinitely.
- out_ready high with out_valid: result transfers at that edge; out_valid = 0 and in_ready = 1 the next cycle.
- out_ready outside DONE is ignored. in_valid while busy is ignored (no queuing).
- Reset mid-transaction aborts it and discards partial results. No out_valid is produced for the aborted request.

## Test plan
- Vectoring, COMPENSATE=1, (1000,1000) → x_out = 1414±2, z_out = 210828714±16384 (45°); out_valid exactly 18 edges after acceptance.
- Vectoring across all quadrants: (−1000,1000), (−1000,−1000), (1000,−1000) → z_out ≈ 632486142, −632486142, −210828714 (±16384); x_out = 1414±2. Also (−1000,0) → z_out ≈ 843314857.
- Rotation, (16384,0), z_in = 281104952 (π/3) → x_out = 8192±3, y_out = 14189±3, |z_out| < 16384. Also z_in = −2π/3 → x_out ≈ −8192, y_out ≈ −14189.
- COMPENSATE=0, vectoring (1000,1000) → x_out = 2329±3. Zero vector (0,0) → x_out = y_out = z_out = 0.
- Backpressure: hold out_ready low 5 cycles in DONE → outputs stable, in_ready = 0, a second in_valid is ignored; release → one transfer, then in_ready = 1.
- Async reset mid-ITER (rst_n low for 1 ns, off-edge) → immediate IDLE, outputs 0, out_valid never asserts; the next request completes normally.

Source files
------------

// File: rtl/cordic_dualmode.sv
`default_nettype none
// ============================================================================
// Module   : cordic_dualmode
// Purpose  : Iterative CORDIC engine, vectoring (magnitude/phase) or rotation
//            selected per request, with quadrant pre-rotation, optional 1/K
//            gain compensation and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_dualmode #(
    parameter int INPUT_WIDTH = 16,
    parameter int INT_WIDTH   = 32,
    parameter int ITERATIONS  = 16,
    parameter int COMPENSATE  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        mode_in,
    input  logic [INPUT_WIDTH-1:0]      x_in,
    input  logic [INPUT_WIDTH-1:0]      y_in,
    input  logic [INT_WIDTH-1:0]        z_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [INT_WIDTH-1:0] x_out,
    output logic signed [INT_WIDTH-1:0] y_out,
    output logic signed [INT_WIDTH-1:0] z_out,
    output logic                        busy
);

    // pi/2 in Q3.28 radians
    localparam logic signed [INT_WIDTH-1:0] c_half_pi = INT_WIDTH'(421657428);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ITER = 3'd2,
        ST_COMP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic                        r_mode;   // 0 = vectoring, 1 = rotation
    logic                        r_zero;   // vectoring request with a (0,0) input
    logic signed [INT_WIDTH-1:0] r_x, r_y, r_z;
    logic [4:0]                  r_iter;

    logic signed [INT_WIDTH-1:0] w_xs, w_ys, w_x_comp, w_y_comp;
    logic                        w_ccw;

    // round(atan(2^-i) * 2^28)
    function automatic logic signed [INT_WIDTH-1:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:  atan_lut = INT_WIDTH'(210828714);
            5'd1:  atan_lut = INT_WIDTH'(124459457);
            5'd2:  atan_lut = INT_WIDTH'(65760959);
            5'd3:  atan_lut = INT_WIDTH'(33381290);
            5'd4:  atan_lut = INT_WIDTH'(16755422);
            5'd5:  atan_lut = INT_WIDTH'(8385879);
            5'd6:  atan_lut = INT_WIDTH'(4193963);
            5'd7:  atan_lut = INT_WIDTH'(2097109);
            5'd8:  atan_lut = INT_WIDTH'(1048571);
            5'd9:  atan_lut = INT_WIDTH'(524287);
            5'd10: atan_lut = INT_WIDTH'(262144);
            5'd11: atan_lut = INT_WIDTH'(131072);
            5'd12: atan_lut = INT_WIDTH'(65536);
            5'd13: atan_lut = INT_WIDTH'(32768);
            5'd14: atan_lut = INT_WIDTH'(16384);
            5'd15: atan_lut = INT_WIDTH'(8192);
            5'd16: atan_lut = INT_WIDTH'(4096);
            5'd17: atan_lut = INT_WIDTH'(2048);
            5'd18: atan_lut = INT_WIDTH'(1024);
            5'd19: atan_lut = INT_WIDTH'(512);
            5'd20: atan_lut = INT_WIDTH'(256);
            5'd21: atan_lut = INT_WIDTH'(128);
            5'd22: atan_lut = INT_WIDTH'(64);
            5'd23: atan_lut = INT_WIDTH'(32);
            default: atan_lut = '0;
        endcase
    endfunction

    // Multiply by 39797/65536 (~1/K) through a double-width signed product
    function automatic logic signed [INT_WIDTH-1:0] scale_inv_k(input logic signed [INT_WIDTH-1:0] v);
        logic signed [2*INT_WIDTH-1:0] p;
        p = signed'({{INT_WIDTH{v[INT_WIDTH-1]}}, v}) * (2*INT_WIDTH)'(39797);
        scale_inv_k = p[INT_WIDTH+15:16];
    endfunction

    assign w_xs  = r_x >>> r_iter;
    assign w_ys  = r_y >>> r_iter;
    // Counter-clockwise step: rotation with z >= 0, or vectoring with y < 0
    assign w_ccw = r_mode ? ~r_z[INT_WIDTH-1] : r_y[INT_WIDTH-1];

    generate
        if (COMPENSATE != 0) begin : g_comp
            assign w_x_comp = scale_inv_k(r_x);
            assign w_y_comp = scale_inv_k(r_y);
        end else begin : g_nocomp
            assign w_x_comp = r_x;
            assign w_y_comp = r_y;
        end
    endgenerate

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid) w_next = ST_PRE;
            ST_PRE:  w_next = ST_ITER;
            ST_ITER: if (r_iter == 5'(ITERATIONS - 1)) w_next = ST_COMP;
            ST_COMP: w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: capture, quadrant pre-rotation, micro-rotations, result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
            r_zero <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_iter <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_mode <= mode_in;
                    r_zero <= ~mode_in & (x_in == '0) & (y_in == '0);
                    r_x    <= {{(INT_WIDTH-INPUT_WIDTH){x_in[INPUT_WIDTH-1]}}, x_in};
                    r_y    <= {{(INT_WIDTH-INPUT_WIDTH){y_in[INPUT_WIDTH-1]}}, y_in};
                    r_z    <= mode_in ? signed'(z_in) : '0;
                    r_iter <= '0;
                end
                ST_PRE: begin
                    if (!r_mode) begin
                        if (r_x[INT_WIDTH-1] && !r_y[INT_WIDTH-1]) begin
                            r_x <= r_y;
                            r_y <= -r_x;
                            r_z <= c_half_pi;
                        end else if (r_x[INT_WIDTH-1]) begin
                            r_x <= -r_y;
                            r_y <= r_x;
                            r_z <= -c_half_pi;
                        end
                    end else begin
                        if (r_z > c_half_pi) begin
                            r_x <= -r_y;
                            r_y <= r_x;
                            r_z <= r_z - c_half_pi;
                        end else if (r_z < -c_half_pi) begin
                            r_x <= r_y;
                            r_y <= -r_x;
                            r_z <= r_z + c_half_pi;
                        end
                    end
                end
                ST_ITER: begin
                    if (w_ccw) begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - atan_lut(r_iter);
                    end else begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + atan_lut(r_iter);
                    end
                    r_iter <= r_iter + 5'd1;
                end
                ST_COMP: begin
                    x_out <= w_x_comp;
                    y_out <= w_y_comp;
                    z_out <= r_zero ? '0 : r_z;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
